// File: rtl/aes_ahb_frontend.sv
// aes_ahb_frontend: AHB-lite register front end for a block-cipher core.
// Staged DIN words are queued as blocks in an input FIFO and handed to the
// core one at a time. Results land in an output FIFO that is read back via DOUT.
module aes_ahb_frontend #(
  parameter int KEY_WORDS = 4,
  parameter int DEPTH     = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic                    HWRITE,
  input  logic                    HREADY,
  input  logic [1:0]              HTRANS,
  input  logic [7:0]              HADDR,
  input  logic [31:0]             HWDATA,
  output logic [31:0]             HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    core_valid,
  input  logic                    core_ready,
  output logic [127:0]            core_blk,
  output logic [32*KEY_WORDS-1:0] core_key,
  output logic                    core_encrypt,
  input  logic                    res_valid,
  input  logic [127:0]            res_blk
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Word indices (HADDR[7:2])
  localparam logic [5:0] IDX_CTRL  = 6'd0;
  localparam logic [5:0] IDX_STAT  = 6'd1;
  localparam logic [5:0] IDX_SCLR  = 6'd2;
  localparam logic [5:0] IDX_DIN3  = 6'd7;
  localparam logic [5:0] IDX_DOUT3 = 6'd19;
  localparam int         IDX_KEY0  = 8;

  generate
    if (!(KEY_WORDS == 4 || KEY_WORDS == 6 || KEY_WORDS == 8)) begin : g_bad_kw
      $error("aes_ahb_frontend: KEY_WORDS must be 4, 6 or 8");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("aes_ahb_frontend: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state_q, state_d;

  logic             acc_q, wr_q;
  logic [5:0]       idx_q;
  logic             en_q, enc_q, ovf_q, klock_q;
  logic [31:0]      din_q [4];
  logic [31:0]      key_q [KEY_WORDS];

  logic [128:0]     imem [DEPTH];
  logic [AW-1:0]    iwp, irp;
  logic [CW-1:0]    icnt;
  logic [127:0]     omem [DEPTH];
  logic [AW-1:0]    owp, orp;
  logic [CW-1:0]    ocnt;

  logic             wr_en, rd_en, wr_ctrl, wr_sclr, wr_din3, wr_key, clr;
  logic             in_full, in_empty, out_full, out_empty, busy, key_lock;
  logic             push_in, pop_in, push_out, pop_out;
  logic [128:0]     ihead;
  logic [31:0]      oword [4];
  logic [31:0]      status, rdata;
  logic             bus_unused;

  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign bus_unused = ^{HADDR[1:0], HTRANS[0]};

  // Address phase capture; the access is acted on in the next (data) phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      acc_q <= 1'b0;
      wr_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      acc_q <= HSEL & HREADY & HTRANS[1];
      wr_q  <= HWRITE;
      idx_q <= HADDR[7:2];
    end
  end

  // Data-phase decode and FIFO handshakes
  always_comb begin
    wr_en     = acc_q & wr_q;
    rd_en     = acc_q & ~wr_q;
    wr_ctrl   = wr_en && (idx_q == IDX_CTRL);
    wr_sclr   = wr_en && (idx_q == IDX_SCLR);
    wr_din3   = wr_en && (idx_q == IDX_DIN3);
    clr       = wr_ctrl & HWDATA[2];
    wr_key    = 1'b0;
    for (int k = 0; k < KEY_WORDS; k++)
      if (wr_en && idx_q == 6'(IDX_KEY0 + k)) wr_key = 1'b1;
    in_full   = (icnt == CW'(DEPTH));
    in_empty  = (icnt == '0);
    out_full  = (ocnt == CW'(DEPTH));
    out_empty = (ocnt == '0);
    busy      = (state_q != S_IDLE);
    // Keys may only change when nothing queued or in flight could see them
    key_lock  = busy | ~in_empty;
    push_in   = wr_din3 & ~in_full;
    pop_in    = core_valid & core_ready;
    push_out  = (state_q == S_WAIT) & res_valid;
    pop_out   = rd_en && (idx_q == IDX_DOUT3) && !out_empty;
    ihead     = imem[irp];
    for (int n = 0; n < 4; n++) oword[n] = omem[orp][127-32*n -: 32];
  end

  // Control, staging, key and sticky status registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_q    <= 1'b0;
      enc_q   <= 1'b0;
      ovf_q   <= 1'b0;
      klock_q <= 1'b0;
      for (int n = 0; n < 4; n++) din_q[n] <= '0;
      for (int k = 0; k < KEY_WORDS; k++) key_q[k] <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q  <= HWDATA[0];
        enc_q <= HWDATA[1];
      end
      if (wr_en && idx_q[5:2] == 4'd1) din_q[idx_q[1:0]] <= HWDATA;
      for (int k = 0; k < KEY_WORDS; k++)
        if (wr_en && !key_lock && idx_q == 6'(IDX_KEY0 + k)) key_q[k] <= HWDATA;
      if (wr_sclr && HWDATA[5]) ovf_q <= 1'b0;
      if (wr_sclr && HWDATA[6]) klock_q <= 1'b0;
      if (wr_din3 && in_full) ovf_q <= 1'b1;
      if (wr_key && key_lock) klock_q <= 1'b1;
    end
  end

  // FIFO storage; contents are qualified by the counts so need no reset
  always_ff @(posedge HCLK) begin
    if (push_in)  imem[iwp] <= {din_q[0], din_q[1], din_q[2], HWDATA, enc_q};
    if (push_out) omem[owp] <= res_blk;
  end

  // FIFO pointers and counts; clear drops everything queued
  always_ff @(posedge HCLK) begin
    if (HRESET || clr) begin
      iwp  <= '0;
      irp  <= '0;
      icnt <= '0;
      owp  <= '0;
      orp  <= '0;
      ocnt <= '0;
    end else begin
      if (push_in) iwp <= iwp + AW'(1);
      if (pop_in)  irp <= irp + AW'(1);
      case ({push_in, pop_in})
        2'b10:   icnt <= icnt + CW'(1);
        2'b01:   icnt <= icnt - CW'(1);
        default: ;
      endcase
      if (push_out) owp <= owp + AW'(1);
      if (pop_out)  orp <= orp + AW'(1);
      case ({push_out, pop_out})
        2'b10:   ocnt <= ocnt + CW'(1);
        2'b01:   ocnt <= ocnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Request FSM state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request FSM next state and core request outputs
  always_comb begin
    state_d      = state_q;
    core_valid   = 1'b0;
    core_blk     = '0;
    core_encrypt = 1'b0;
    case (state_q)
      // Only start when the output FIFO has room for the result
      S_IDLE: if (en_q && !in_empty && !out_full) state_d = S_REQ;
      S_REQ: begin
        core_valid   = ~HRESET;
        core_blk     = HRESET ? '0 : ihead[128:1];
        core_encrypt = ~HRESET & ihead[0];
        if (core_ready) state_d = S_WAIT;
      end
      S_WAIT: if (res_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  // Key words presented MSW first
  always_comb begin
    core_key = '0;
    for (int k = 0; k < KEY_WORDS; k++)
      core_key[32*(KEY_WORDS-1-k) +: 32] = key_q[k];
  end

  // Status word and read mux
  always_comb begin
    status        = '0;
    status[0]     = in_full;
    status[1]     = in_empty;
    status[2]     = out_full;
    status[3]     = out_empty;
    status[4]     = busy;
    status[5]     = ovf_q;
    status[6]     = klock_q;
    status[11:8]  = 4'(icnt);
    status[19:16] = 4'(ocnt);
    rdata = '0;
    case (idx_q)
      IDX_CTRL: rdata = {30'b0, enc_q, en_q};
      IDX_STAT: rdata = status;
      default:  ;
    endcase
    if (idx_q[5:2] == 4'd1) rdata = din_q[idx_q[1:0]];
    for (int k = 0; k < KEY_WORDS; k++)
      if (idx_q == 6'(IDX_KEY0 + k)) rdata = key_q[k];
    if (idx_q[5:2] == 4'd4 && !out_empty) rdata = oword[idx_q[1:0]];
    HRDATA = (rd_en && !HRESET) ? rdata : '0;
  end

endmodule
